// File: rtl/flash_sample_streamer.sv
// -----------------------------------------------------------------------------
// flash_sample_streamer
//
// Upstream stage of the audio playback path. Reads 32-bit words sequentially
// from the flash Avalon-MM slave, splits each word into two signed 16-bit
// samples (low half first), attenuates each by an arithmetic right shift and
// buffers them in a small first-word-fall-through FIFO for the codec writer.
//
// Ports
//   clk                      system clock (CLOCK_50 domain)
//   reset                    synchronous, active-high reset
//   enable                   allows new flash reads to be issued
//   flash_mem_read           Avalon read request (held while waitrequest=1)
//   flash_mem_address        Avalon word address
//   flash_mem_byteenable     constant 4'b1111
//   flash_mem_waitrequest    Avalon stall
//   flash_mem_readdata       Avalon read data
//   flash_mem_readdatavalid  Avalon read data strobe
//   sample_valid             FIFO non-empty
//   sample_ready             consumer accepts the head sample this cycle
//   sample_data              signed sample at the FIFO head
//   wrapped                  one-cycle pulse when the address wraps to 0
//   fsm_state                current FSM state, for observation only
//
// Handshake: a sample transfers on every rising clk edge where
// sample_valid && sample_ready are both high; sample_valid never depends on
// sample_ready, and sample_data is stable while sample_valid is high and no
// transfer has happened. A flash read is accepted on the edge where
// flash_mem_read=1 and flash_mem_waitrequest=0.
// -----------------------------------------------------------------------------
module flash_sample_streamer #(
   parameter int ADDR_W     = 23,
   parameter int NUM_WORDS  = 1048576,
   parameter int FIFO_DEPTH = 8,
   parameter int SHIFT      = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   input  logic              flash_mem_waitrequest,
   input  logic [31:0]       flash_mem_readdata,
   input  logic              flash_mem_readdatavalid,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [15:0]       sample_data,
   output logic              wrapped,
   output logic [2:0]        fsm_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // A read may start only if both halves of the word will fit.
   localparam logic [CNT_W-1:0]  ISSUE_MAX_COUNT = CNT_W'(FIFO_DEPTH - 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR       = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DATA = 3'd2,
      PUSH_LO   = 3'd3,
      PUSH_HI   = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [31:0]        word_q;
   logic signed [15:0] lo_half;
   logic signed [15:0] hi_half;
   logic signed [15:0] lo_shift;
   logic signed [15:0] hi_shift;

   logic [15:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic [15:0]        push_data;

   assign lo_half  = word_q[15:0];
   assign hi_half  = word_q[31:16];
   assign lo_shift = lo_half >>> SHIFT;
   assign hi_shift = hi_half >>> SHIFT;

   // ---------------------------------------------------------------------
   // FSM: next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      flash_mem_read = 1'b0;
      push           = 1'b0;
      push_data      = lo_shift;
      case (state)
         IDLE: begin
            if (enable && (count <= ISSUE_MAX_COUNT)) state_nxt = ISSUE;
         end
         ISSUE: begin
            flash_mem_read = 1'b1;
            if (!flash_mem_waitrequest) state_nxt = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (flash_mem_readdatavalid) state_nxt = PUSH_LO;
         end
         PUSH_LO: begin
            push      = 1'b1;
            push_data = lo_shift;
            state_nxt = PUSH_HI;
         end
         PUSH_HI: begin
            push      = 1'b1;
            push_data = hi_shift;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM state, address and wrap pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         flash_mem_address <= '0;
         wrapped           <= 1'b0;
      end else begin
         state   <= state_nxt;
         wrapped <= 1'b0;
         if (state == PUSH_HI) begin
            if (flash_mem_address == LAST_ADDR) begin
               flash_mem_address <= '0;
               wrapped           <= 1'b1;
            end else begin
               flash_mem_address <= flash_mem_address + ADDR_W'(1);
            end
         end
      end
   end

   // Data is captured only in WAIT_DATA, so a strobe belonging to a read
   // abandoned by reset is dropped.
   always_ff @(posedge clk) begin
      if (state == WAIT_DATA && flash_mem_readdatavalid) word_q <= flash_mem_readdata;
   end

   // ---------------------------------------------------------------------
   // Sample FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------
   assign pop = (count != '0) && sample_ready;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign sample_valid         = (count != '0);
   assign sample_data          = fifo_mem[rd_ptr];
   assign flash_mem_byteenable = 4'b1111;
   assign fsm_state            = state;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// -----------------------------------------------------------------------------
// tb_flash_sample_streamer
//
// Bench for flash_sample_streamer (NUM_WORDS=4, FIFO_DEPTH=8, SHIFT=6).
// A flash slave model answers reads from a 4-word memory with a programmable
// waitrequest stall and read latency; every returned word predicts two
// attenuated samples in exp_q, which are compared against each accepted
// sample. Directed phases add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_flash_sample_streamer;

   localparam int ADDR_W = 23;
   localparam int NW     = 4;
   localparam int DEPTH  = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              flash_mem_read;
   logic [ADDR_W-1:0] flash_mem_address;
   logic [3:0]        flash_mem_byteenable;
   logic              flash_mem_waitrequest = 1'b0;
   logic [31:0]       flash_mem_readdata = 32'h0;
   logic              flash_mem_readdatavalid = 1'b0;
   logic              sample_valid;
   logic              sample_ready = 1'b0;
   logic [15:0]       sample_data;
   logic              wrapped;
   logic [2:0]        fsm_state;

   flash_sample_streamer #(
      .ADDR_W(ADDR_W), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH), .SHIFT(6)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .flash_mem_read(flash_mem_read),
      .flash_mem_address(flash_mem_address),
      .flash_mem_byteenable(flash_mem_byteenable),
      .flash_mem_waitrequest(flash_mem_waitrequest),
      .flash_mem_readdata(flash_mem_readdata),
      .flash_mem_readdatavalid(flash_mem_readdatavalid),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_data(sample_data),
      .wrapped(wrapped),
      .fsm_state(fsm_state)
   );

   // ---------------- bench state ----------------
   int errors = 0;
   int checks = 0;

   // configuration set by the sequencer at negedge, applied by the slave at posedge+1
   logic rst_cfg = 1'b1;
   logic en_cfg  = 1'b0;
   logic rdy_cfg = 1'b0;
   int   wait_n  = 0;
   int   lat     = 1;

   logic [31:0] fm [NW];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];

   int   exp_addr = 0;
   int   exp_wraps = 0;
   int   wrap_pulses = 0;
   int   accepts = 0;
   int   stall_cnt = 0;
   int   pops = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   first_valid_cyc = 0;
   int   last_acc_addr = 0;
   int   issue_cnt = 0;
   logic [ADDR_W-1:0] first_addr = '0;
   logic pend = 1'b0;
   logic pend_stale = 1'b0;
   int   pend_cd = 0;
   int   pend_addr = 0;
   logic prev_valid = 1'b0;
   logic prev_wrapped = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Attenuation as floor division by 64 of the signed half-word.
   function automatic logic [15:0] atten(input logic [15:0] h);
      int v;
      int q;
      v = (h >= 16'h8000) ? int'(h) - 65536 : int'(h);
      q = (v < 0) ? -((-v + 63) / 64) : v / 64;
      return q[15:0];
   endfunction

   // ---------------- flash slave + scoreboard ----------------
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         reset                   = rst_cfg;
         enable                  = en_cfg;
         sample_ready            = rdy_cfg;
         flash_mem_readdatavalid = 1'b0;
         flash_mem_readdata      = 32'h0;
         flash_mem_waitrequest   = 1'b0;

         check("byteenable", 32'(flash_mem_byteenable), 32'hF);
         if (wrapped) begin
            wrap_pulses++;
            check("wrap_addr_zero", 32'(flash_mem_address), 32'h0);
            check("wrap_single_cycle", 32'(prev_wrapped), 32'h0);
         end

         if (reset) begin
            exp_q.delete();
            exp_addr  = 0;
            issue_cnt = 0;
            if (pend) pend_stale = 1'b1;
         end

         // read data return
         if (pend) begin
            pend_cd--;
            if (pend_cd <= 0) begin
               flash_mem_readdatavalid = 1'b1;
               flash_mem_readdata      = pend_stale ? 32'h12345678 : fm[pend_addr];
               if (!pend_stale) begin
                  if (exp_q.size() > DEPTH - 2) fail("fifo_overflow");
                  exp_q.push_back(atten(fm[pend_addr][15:0]));
                  exp_q.push_back(atten(fm[pend_addr][31:16]));
                  if (pend_addr == NW - 1) exp_wraps++;
               end
               pend       = 1'b0;
               pend_stale = 1'b0;
            end
         end

         // read request
         if (flash_mem_read && !reset) begin
            if (pend) fail("second_outstanding_read");
            if (issue_cnt == 0) first_addr = flash_mem_address;
            else check("addr_stable_in_stall", 32'(flash_mem_address), 32'(first_addr));
            if (issue_cnt < wait_n) begin
               flash_mem_waitrequest = 1'b1;
               stall_cnt++;
               issue_cnt++;
            end else begin
               check("read_addr", 32'(flash_mem_address), 32'(exp_addr));
               accepts++;
               accept_cyc    = cyc;
               last_acc_addr = int'(flash_mem_address);
               pend          = 1'b1;
               pend_stale    = 1'b0;
               pend_cd       = lat;
               pend_addr     = exp_addr;
               exp_addr      = (exp_addr + 1) % NW;
               issue_cnt     = 0;
            end
         end

         // sample transfer
         if (sample_valid && !prev_valid) first_valid_cyc = cyc;
         if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_sample");
            end else begin
               e = exp_q.pop_front();
               check("sample", 32'(sample_data), 32'(e));
            end
            got_q.push_back(sample_data);
            pops++;
         end
         prev_valid   = sample_valid;
         prev_wrapped = wrapped;
      end
   end

   // ---------------- sequencer helpers ----------------
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_enable();
      @(negedge clk);
      en_cfg = 1'b1;
      @(negedge clk);
      en_cfg = 1'b0;
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (got_q.size() < n) fail(name);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int a0;
      int s0;
      int p0;
      int w0;
      int g0;
      int hi_run;
      int k;

      fm[0] = 32'h7FFF8000;
      fm[1] = 32'hFFC01234;
      fm[2] = 32'h00400FC0;
      fm[3] = 32'h80017FC1;

      // reset state
      cycles(4);
      check("reset_read", 32'(flash_mem_read), 32'h0);
      check("reset_addr", 32'(flash_mem_address), 32'h0);
      check("reset_valid", 32'(sample_valid), 32'h0);
      check("reset_wrapped", 32'(wrapped), 32'h0);
      check("reset_state", 32'(fsm_state), 32'h0);
      rst_cfg = 1'b0;
      cycles(2);

      // word 0x7FFF8000 at address 0, latency 3
      rdy_cfg = 1'b1;
      lat     = 3;
      pulse_enable();
      wait_got(2, 100, "timeout_word0");
      cycles(3);
      if (got_q.size() >= 2) begin
         check("word0_lo", 32'(got_q[0]), 32'h0000FE00);
         check("word0_hi", 32'(got_q[1]), 32'h000001FF);
      end
      check("first_sample_latency", 32'(first_valid_cyc - accept_cyc), 32'(lat + 2));
      check("addr_after_word0", 32'(flash_mem_address), 32'h1);

      // word 0xFFC01234: sign extension of the shift
      lat = 1;
      pulse_enable();
      wait_got(4, 100, "timeout_word1");
      cycles(3);
      if (got_q.size() >= 4) begin
         check("word1_lo", 32'(got_q[2]), 32'h00000048);
         check("word1_hi", 32'(got_q[3]), 32'h0000FFFF);
      end
      check("addr_after_word1", 32'(flash_mem_address), 32'h2);

      // consumer stalled for 200 cycles: FIFO fills with exactly 4 words
      a0 = accepts;
      w0 = wrap_pulses;
      @(negedge clk);
      rdy_cfg = 1'b0;
      en_cfg  = 1'b1;
      cycles(200);
      check("stall_reads", 32'(accepts - a0), 32'h4);
      check("stall_read_low", 32'(flash_mem_read), 32'h0);
      check("stall_valid", 32'(sample_valid), 32'h1);
      check("stall_wraps", 32'(wrap_pulses - w0), 32'h1);
      p0      = pops;
      en_cfg  = 1'b0;
      rdy_cfg = 1'b1;
      hi_run  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sample_valid) hi_run++;
      end
      check("drain_pops", 32'(pops - p0), 32'h8);
      check("drain_one_per_cycle", 32'(hi_run), 32'h8);

      // waitrequest held for 5 cycles
      a0     = accepts;
      s0     = stall_cnt;
      g0     = got_q.size();
      wait_n = 5;
      pulse_enable();
      wait_got(g0 + 2, 100, "timeout_waitreq");
      cycles(3);
      check("waitreq_stalls", 32'(stall_cnt - s0), 32'h5);
      check("waitreq_one_txn", 32'(accepts - a0), 32'h1);
      check("addr_after_waitreq", 32'(flash_mem_address), 32'h3);
      wait_n = 0;

      // free running through several wraps
      @(negedge clk);
      en_cfg = 1'b1;
      cycles(60);
      en_cfg = 1'b0;
      cycles(20);
      check("wrap_count", 32'(wrap_pulses), 32'(exp_wraps));
      check("drained_all", 32'(exp_q.size()), 32'h0);
      check("drained_valid", 32'(sample_valid), 32'h0);

      // reset during WAIT_DATA, then a stale readdatavalid
      lat = 10;
      g0  = got_q.size();
      pulse_enable();
      k = 0;
      while (!pend && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!pend) fail("timeout_reset_read");
      cycles(2);
      rst_cfg = 1'b1;
      cycles(3);
      rst_cfg = 1'b0;
      k = 0;
      while (pend && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (pend) fail("timeout_stale_data");
      cycles(5);
      check("stale_valid", 32'(sample_valid), 32'h0);
      check("stale_no_samples", 32'(got_q.size() - g0), 32'h0);
      check("stale_addr", 32'(flash_mem_address), 32'h0);
      check("stale_state", 32'(fsm_state), 32'h0);
      lat = 1;
      pulse_enable();
      wait_got(g0 + 2, 100, "timeout_after_reset");
      cycles(3);
      check("post_reset_read_addr", 32'(last_acc_addr), 32'h0);
      if (got_q.size() >= g0 + 2) begin
         check("post_reset_lo", 32'(got_q[g0]), 32'h0000FE00);
         check("post_reset_hi", 32'(got_q[g0 + 1]), 32'h000001FF);
      end
      check("post_reset_addr", 32'(flash_mem_address), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
